// File: rtl/mul_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM state codes and
// a constant width helper for the step counter.
package mul_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Smallest r with 2**r >= value; used to size a counter that must hold
  // values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mul_seq_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand,
// followed by an arithmetic right shift of {acc, q, q_m1}.
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] acc,
  input  logic [WIDTH:0]   q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH+1:0] acc_n,
  output logic [WIDTH:0]   q_n,
  output logic             q_m1_n
);

  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] sum;

  // NOTE: every variable written in always_comb gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    m_ext = {m[WIDTH], m};
    sum   = acc;
    case ({q[0], q_m1})
      2'b01:   sum = acc + m_ext;
      2'b10:   sum = acc - m_ext;
      default: sum = acc;
    endcase
  end

  assign acc_n  = {sum[WIDTH+1], sum[WIDTH+1:1]};
  assign q_n    = {sum[0], q[WIDTH:1]};
  assign q_m1_n = q[0];

endmodule

// File: rtl/mul_seq_booth.sv
// Iterative radix-2 Booth multiplier with start/busy/done handshake; one
// partial-product step per clock, signed or unsigned chosen per operation.
module mul_seq_booth
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   m_q;
  logic [WIDTH+1:0] acc_q;
  logic [WIDTH:0]   q_q;
  logic             q_m1_q;

  logic [WIDTH+1:0]   acc_n;
  logic [WIDTH:0]     q_n;
  logic               q_m1_n;
  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     b_ext;
  logic [2*WIDTH-1:0] prod_n;
  logic               last_step;

  // One extra operand bit lets a single signed Booth datapath cover unsigned
  // operands too: zero-extension makes them non-negative signed values.
  assign a_ext = signed_mode ? {a[WIDTH-1], a} : {1'b0, a};
  assign b_ext = signed_mode ? {b[WIDTH-1], b} : {1'b0, b};

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc    (acc_q),
    .q      (q_q),
    .q_m1   (q_m1_q),
    .m      (m_q),
    .acc_n  (acc_n),
    .q_n    (q_n),
    .q_m1_n (q_m1_n)
  );

  // The exact product always fits in the low 2*WIDTH bits of {acc, q}.
  assign prod_n    = {acc_n[WIDTH-2:0], q_n};
  assign last_step = (count == CW'(WIDTH));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      count   <= '0;
      product <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q_m1_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state  <= ST_RUN;
            m_q    <= a_ext;
            q_q    <= b_ext;
            acc_q  <= '0;
            q_m1_q <= 1'b0;
            count  <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_q  <= acc_n;
          q_q    <= q_n;
          q_m1_q <= q_m1_n;
          count  <= count + CW'(1);
          if (last_step) begin
            state   <= ST_DONE;
            product <= prod_n;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mul_seq_booth.sv
// Directed and random checks of mul_seq_booth at WIDTH=32 and WIDTH=8:
// products, latency, handshake corner cases and reset behaviour.
module tb_mul_seq_booth;

  logic        clk = 1'b0;
  logic        rst;

  logic        start32, sm32;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [63:0] product32;

  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] product8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_seq_booth #(.WIDTH(32)) dut32 (
    .clk         (clk),
    .rst         (rst),
    .start       (start32),
    .signed_mode (sm32),
    .a           (a32),
    .b           (b32),
    .busy        (busy32),
    .done        (done32),
    .product     (product32)
  );

  mul_seq_booth #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (start8),
    .signed_mode (sm8),
    .a           (a8),
    .b           (b8),
    .busy        (busy8),
    .done        (done8),
    .product     (product8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts edges until done is seen (sampled 1 time unit after each edge).
  task automatic wait_done32(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = busy32 ? 1 : 0;
    while (!done32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy32) busy_cycles++;
    end
  endtask

  task automatic op32(input logic [31:0] ia, input logic [31:0] ib, input logic sm,
                      output logic [63:0] p, output int lat, output int busy_cycles);
    @(negedge clk);
    a32 = ia; b32 = ib; sm32 = sm; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    // Scramble inputs to show the operands were latched at the accepting edge.
    a32 = ~ia; b32 = ~ib; sm32 = ~sm;
    wait_done32(lat, busy_cycles);
    p = product32;
  endtask

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic sm,
                     output logic [15:0] p, output int lat);
    @(negedge clk);
    a8 = ia; b8 = ib; sm8 = sm; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~ia; b8 = ~ib;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    p = product8;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] p;
    logic [15:0] p8;
    logic [7:0]  ra, rb;
    logic [15:0] exp8;
    int lat, bc, done_cnt, first_done;

    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vecs[3] = '{32'h0000_0000, 32'h1234_5678, 1'b0, 64'h0000_0000_0000_0000};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
    vecs[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000};
    vecs[7] = '{32'h1234_5678, 32'h0000_0002, 1'b0, 64'h0000_0000_2468_ACF0};
    vecs[8] = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[9] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000};

    rst = 1'b1;
    start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy32", 64'(busy32), 64'd0);
    check("reset done32", 64'(done32), 64'd0);
    check("reset product32", product32, 64'd0);
    check("reset product8", 64'(product8), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven products; done appears after edge t+WIDTH+1, i.e. in the
    // cycle ending at edge t+34, and busy spans WIDTH+1 cycles.
    for (int i = 0; i < 10; i++) begin
      op32(vecs[i].a, vecs[i].b, vecs[i].sm, p, lat, bc);
      check($sformatf("vec%0d product", i), p, vecs[i].exp);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd33);
      check($sformatf("vec%0d busy cycles", i), 64'(bc), 64'd33);
    end

    // Held output: product stays put in IDLE.
    repeat (3) @(posedge clk);
    #1;
    check("idle hold product", product32, 64'h0000_0001_0000_0000);
    check("idle busy", 64'(busy32), 64'd0);

    // start pulsed mid-RUN must be ignored.
    @(negedge clk);
    a32 = 32'd6; b32 = 32'd7; sm32 = 1'b0; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    a32 = 32'd100; b32 = 32'd100; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    done_cnt = 0;
    first_done = -1;
    for (int e = 7; e <= 80; e++) begin
      @(posedge clk); #1;
      if (done32) begin
        done_cnt++;
        if (first_done < 0) first_done = e;
      end
    end
    check("midrun done edge", 64'(first_done), 64'd33);
    check("midrun done pulses", 64'(done_cnt), 64'd1);
    check("midrun product", product32, 64'd42);

    // Reset at count=10 discards the operation.
    @(negedge clk);
    a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; sm32 = 1'b0; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst mid busy", 64'(busy32), 64'd0);
    check("rst mid done", 64'(done32), 64'd0);
    check("rst mid product", product32, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (done32 || busy32) done_cnt++;
    end
    check("rst no activity after", 64'(done_cnt), 64'd0);

    // start held through DONE: back-to-back accept with no IDLE gap.
    @(negedge clk);
    a32 = 32'hFFFF_FFFD; b32 = 32'd5; sm32 = 1'b1; start32 = 1'b1;
    @(posedge clk); #1;
    a32 = 32'd7; b32 = 32'd6; sm32 = 1'b0;
    wait_done32(lat, bc);
    check("b2b first product", product32, 64'hFFFF_FFFF_FFFF_FFF1);
    check("b2b first latency", 64'(lat), 64'd33);
    @(posedge clk); #1;
    start32 = 1'b0;
    check("b2b busy reasserted", 64'(busy32), 64'd1);
    check("b2b done dropped", 64'(done32), 64'd0);
    check("b2b product held in RUN", product32, 64'hFFFF_FFFF_FFFF_FFF1);
    wait_done32(lat, bc);
    check("b2b second product", product32, 64'd42);
    check("b2b second latency", 64'(lat), 64'd33);
    @(posedge clk); #1;
    check("b2b back to idle", 64'(busy32 | done32), 64'd0);

    // WIDTH=8 instance.
    op8(8'hFF, 8'h02, 1'b0, p8, lat);
    check("w8 unsigned FFx02", 64'(p8), 64'h01FE);
    check("w8 latency", 64'(lat), 64'd9);
    op8(8'hFF, 8'h02, 1'b1, p8, lat);
    check("w8 signed FFx02", 64'(p8), 64'hFFFE);
    op8(8'h80, 8'h80, 1'b1, p8, lat);
    check("w8 signed minxmin", 64'(p8), 64'h4000);

    for (int mode = 0; mode < 2; mode++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        if (mode == 1)
          exp8 = 16'($signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb}));
        else
          exp8 = 16'({8'd0, ra} * {8'd0, rb});
        op8(ra, rb, mode[0], p8, lat);
        check($sformatf("w8 rand m%0d %02h*%02h", mode, ra, rb), 64'(p8), 64'(exp8));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
